// File: rtl/tdm_mux_if.sv
// tdm_mux_if: per-channel data/request/ready into the mux, serial beat and slot acks out of it
// master: the mux side (takes d/req/rdy, drives o/sel/valid/ack); slave: the channel/downstream side
interface tdm_mux_if;
  logic [7:0] d;
  logic [7:0] req;
  logic       rdy;
  logic       o;
  logic [2:0] sel;
  logic       valid;
  logic [7:0] ack;
  modport master (input d, req, rdy, output o, sel, valid, ack);
  modport slave (output d, req, rdy, input o, sel, valid, ack);
endinterface

// File: rtl/tdm_mux.sv
// tdm_mux: eight-channel round-robin TDM collector driving one serial bit plus its 3-bit channel index
// Ports: clk, rst_n (async active-low); bus.master takes d/req (channel k on bit 7-k) and rdy,
// and drives registered o/sel/valid plus a one-cycle one-hot ack (channel k on bit 7-k)
module tdm_mux #(
  parameter int SLOT_CYCLES = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  tdm_mux_if.master bus
);
  localparam int CW = $clog2(SLOT_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(SLOT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t        st_q, st_d;
  logic [2:0]    ptr_q, ptr_d, sel_q, sel_d, win;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          o_q, o_d, valid_q, valid_d;
  logic [7:0]    ack_q, ack_d, r, rot;
  always_comb begin
    // r[k] is channel k's request; rot[i] is the request of channel ptr+i
    r = {<<{bus.req}};
    rot = 8'({r, r} >> ptr_q);
    win = ptr_q;
    for (int i = 7; i >= 0; i--) if (rot[i]) win = ptr_q + 3'(i);
    st_d = st_q;
    ptr_d = ptr_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    o_d = o_q;
    valid_d = valid_q;
    ack_d = 8'h00;
    case (st_q)
      IDLE: if (|r) begin
        st_d = SEND;
        sel_d = win;
        o_d = bus.d[~win];
        valid_d = 1'b1;
        cnt_d = '0;
      end
      SEND: if (bus.rdy) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          st_d = DONE;
          valid_d = 1'b0;
          ack_d = 8'h80 >> sel_q;
          ptr_d = sel_q + 3'd1;
        end
      end
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q <= IDLE;
      ptr_q <= '0;
      sel_q <= '0;
      cnt_q <= '0;
      o_q <= 1'b0;
      valid_q <= 1'b0;
      ack_q <= 8'h00;
    end else begin
      st_q <= st_d;
      ptr_q <= ptr_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      o_q <= o_d;
      valid_q <= valid_d;
      ack_q <= ack_d;
    end
  assign bus.o = o_q;
  assign bus.sel = sel_q;
  assign bus.valid = valid_q;
  assign bus.ack = ack_q;
endmodule

// File: tb/tb_tdm_mux.sv
// tb_tdm_mux: directed vector bench for tdm_mux with one-beat and two-beat slot instances
module tb_tdm_mux;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_tot = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  tdm_mux_if b1();
  tdm_mux_if b2();
  tdm_mux #(.SLOT_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  tdm_mux #(.SLOT_CYCLES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  typedef struct {
    logic [7:0] req;
    logic [7:0] d;
    logic       rdy;
    logic       o;
    logic [2:0] sel;
    logic       valid;
    logic [7:0] ack;
  } vec_t;
  vec_t tv[15];
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else n_pass++;
  endtask
  task automatic chk1(input string nm, input logic o, input logic [2:0] sel, input logic valid, input logic [7:0] ack);
    chk({nm, "_o"}, 8'(b1.o), 8'(o));
    chk({nm, "_sel"}, 8'(b1.sel), 8'(sel));
    chk({nm, "_valid"}, 8'(b1.valid), 8'(valid));
    chk({nm, "_ack"}, b1.ack, ack);
  endtask
  initial begin
    int grants, last, expc, prevch;
    int t[8];
    logic [7:0] dcap;
    logic pat[4];
    b1.d = 0; b1.req = 0; b1.rdy = 1;
    b2.d = 0; b2.req = 0; b2.rdy = 1;
    // reset with noisy inputs, then idle
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b1.d = 8'($urandom); b1.req = 8'($urandom);
      step;
      chk1("rst", 1'b0, 3'd0, 1'b0, 8'h00);
    end
    rst_n = 1'b1; b1.req = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step;
      chk("rst_idle_valid", 8'(b1.valid), 8'd0);
    end
    // single request on channel 2, then channel 5 to move ptr to 6, then 7/1 wrap and ptr=0 proof
    tv[0]  = '{8'h20, 8'h20, 1'b1, 1'b1, 3'd2, 1'b1, 8'h00};
    tv[1]  = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd2, 1'b0, 8'h20};
    tv[2]  = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd2, 1'b0, 8'h00};
    tv[3]  = '{8'h04, 8'h04, 1'b1, 1'b1, 3'd5, 1'b1, 8'h00};
    tv[4]  = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd5, 1'b0, 8'h04};
    tv[5]  = '{8'h41, 8'h01, 1'b1, 1'b1, 3'd5, 1'b0, 8'h00};
    tv[6]  = '{8'h41, 8'h01, 1'b1, 1'b1, 3'd7, 1'b1, 8'h00};
    tv[7]  = '{8'h40, 8'h01, 1'b1, 1'b1, 3'd7, 1'b0, 8'h01};
    tv[8]  = '{8'hC0, 8'h80, 1'b1, 1'b1, 3'd7, 1'b0, 8'h00};
    tv[9]  = '{8'hC0, 8'h80, 1'b1, 1'b1, 3'd0, 1'b1, 8'h00};
    tv[10] = '{8'h40, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 8'h80};
    tv[11] = '{8'h40, 8'h40, 1'b1, 1'b1, 3'd0, 1'b0, 8'h00};
    tv[12] = '{8'h40, 8'h40, 1'b1, 1'b1, 3'd1, 1'b1, 8'h00};
    tv[13] = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd1, 1'b0, 8'h40};
    tv[14] = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd1, 1'b0, 8'h00};
    for (int i = 0; i < 15; i++) begin
      b1.req = tv[i].req; b1.d = tv[i].d; b1.rdy = tv[i].rdy;
      step;
      chk1($sformatf("vec%0d", i), tv[i].o, tv[i].sel, tv[i].valid, tv[i].ack);
    end
    // all channels requesting, each dropping on its ack and re-raising two cycles later
    rst_n = 1'b0; step; rst_n = 1'b1;
    grants = 0; last = 0; expc = 0; prevch = 0;
    for (int k = 0; k < 8; k++) t[k] = 0;
    b1.req = 8'hFF; b1.rdy = 1'b1;
    for (int c = 0; c < 27; c++) begin
      for (int k = 0; k < 8; k++) if (t[k] > 0) begin
        t[k]--;
        if (t[k] == 0) b1.req[7-k] = 1'b1;
      end
      dcap = 8'($urandom); b1.d = dcap;
      step;
      if (b1.valid) begin
        chk("rr_sel", 8'(b1.sel), 8'(expc));
        chk("rr_o", 8'(b1.o), 8'(dcap[7-expc]));
        if (grants > 0) chk("rr_gap", 8'(c - last), 8'd3);
        last = c; grants++; prevch = expc; expc = (expc + 1) % 8;
      end
      if (b1.ack != 8'h00) begin
        chk("rr_ack", b1.ack, 8'h80 >> prevch);
        for (int k = 0; k < 8; k++) if (b1.ack[7-k]) begin
          b1.req[7-k] = 1'b0;
          t[k] = 2;
        end
      end
    end
    chk("rr_grants", 8'(grants), 8'd9);
    b1.req = 8'h00;
    // backpressure on the two-beat instance, channel 4, with d/req churn mid-slot
    b2.req = 8'h08; b2.d = 8'h08; b2.rdy = 1'b1;
    step;
    chk("bp_grant_valid", 8'(b2.valid), 8'd1);
    chk("bp_grant_sel", 8'(b2.sel), 8'd4);
    chk("bp_grant_o", 8'(b2.o), 8'd1);
    b2.d = 8'h00; b2.req = 8'hFF;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      b2.rdy = pat[i];
      step;
      chk($sformatf("bp%0d_valid", i), 8'(b2.valid), i < 3 ? 8'd1 : 8'd0);
      chk($sformatf("bp%0d_sel", i), 8'(b2.sel), 8'd4);
      chk($sformatf("bp%0d_o", i), 8'(b2.o), 8'd1);
      chk($sformatf("bp%0d_ack", i), b2.ack, i < 3 ? 8'h00 : 8'h08);
    end
    b2.req = 8'h00;
    step;
    chk("bp_done_ack", b2.ack, 8'h00);
    chk("bp_done_valid", 8'(b2.valid), 8'd0);
    step;
    chk("bp_idle_valid", 8'(b2.valid), 8'd0);
    // reset in the middle of channel 3's slot
    b1.rdy = 1'b0; b1.req = 8'h10; b1.d = 8'h10;
    step;
    chk("mid_valid", 8'(b1.valid), 8'd1);
    chk("mid_sel", 8'(b1.sel), 8'd3);
    #2 rst_n = 1'b0;
    #1;
    chk1("mid_rst", 1'b0, 3'd0, 1'b0, 8'h00);
    step;
    chk1("mid_rst_hold", 1'b0, 3'd0, 1'b0, 8'h00);
    rst_n = 1'b1; b1.rdy = 1'b1;
    chk("mid_ptr", 8'(dut1.ptr_q), 8'd0);
    step;
    chk1("regrant", 1'b1, 3'd3, 1'b1, 8'h00);
    step;
    chk1("regrant_ack", 1'b1, 3'd3, 1'b0, 8'h10);
    b1.req = 8'h00;
    step;
    chk1("regrant_done", 1'b1, 3'd3, 1'b0, 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
